// File: rtl/apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_regfile
//  Purpose  : APB3 completer holding a small 32-bit register bank:
//             word 0 = read-only ID, word 1 = wait-state config (bits [3:0]),
//             words 2..NUM_REGS-1 = scratch read/write.  Each transfer is
//             stretched by WAIT_CFG[3:0] wait cycles.  Invalid accesses
//             (unaligned, out of range, write to ID) answer with pslverr.
//  Ports    : hclk     - clock
//             hreset_n - asynchronous active-low reset
//             psel, penable, pwrite, paddr, pwdata - APB request
//             prdata, pready, pslverr              - APB response
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regfile #(
  parameter int          ADDR_W   = 12,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA2B0_0001,
  parameter logic [3:0]  WAIT_RST = 4'd0
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_write;
  logic [31:0]      r_wdata;
  logic [3:0]       r_cnt;
  logic             r_err;
  logic [3:0]       r_wait_cfg;
  logic [31:0]      r_scratch [2:NUM_REGS-1];

  logic [IDX_W-1:0] w_idx;
  logic             w_setup_err;
  logic             w_setup;
  logic             w_complete;
  logic             w_wr_en;
  logic [31:0]      w_rd_val;

  assign w_idx = paddr[ADDR_W-1:2];

  // Error is decided at setup time from the live bus so the access phase
  // only has to replay it.
  assign w_setup_err = (paddr[1:0] != 2'b00)
                    || (32'(w_idx) >= 32'(NUM_REGS))
                    || (pwrite && (w_idx == '0));

  // A setup phase is accepted in IDLE and also in ACCESS (psel high with
  // penable low restarts the transfer).
  assign w_setup    = psel && !penable;
  assign w_complete = (r_state == S_ACCESS) && psel && penable && (r_cnt == 4'd0);
  assign w_wr_en    = w_complete && r_write && !r_err;

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else if (w_setup) begin
      r_state <= S_ACCESS;
      r_idx   <= w_idx;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_cnt   <= r_wait_cfg;
      r_err   <= w_setup_err;
    end else if (r_state == S_ACCESS) begin
      if (!psel) begin
        // Abandoned transfer: drop back without touching the registers.
        r_state <= S_IDLE;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_wait_cfg <= WAIT_RST;
    end else if (w_wr_en && (r_idx == IDX_W'(1))) begin
      r_wait_cfg <= r_wdata[3:0];
    end
  end

  for (genvar k = 2; k < NUM_REGS; k++) begin : g_scratch
    always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
        r_scratch[k] <= '0;
      end else if (w_wr_en && (r_idx == IDX_W'(k))) begin
        r_scratch[k] <= r_wdata;
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    if (r_idx == IDX_W'(0)) begin
      w_rd_val = ID_VALUE;
    end else if (r_idx == IDX_W'(1)) begin
      w_rd_val = {28'd0, r_wait_cfg};
    end else begin
      for (int k = 2; k < NUM_REGS; k++) begin
        if (r_idx == IDX_W'(k)) begin
          w_rd_val = r_scratch[k];
        end
      end
    end
  end

  // Response is qualified by pready so prdata/pslverr read as zero while
  // the transfer is still stalled.
  assign pready  = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign prdata  = (pready && !r_err && !r_write) ? w_rd_val : 32'd0;
  assign pslverr = pready && r_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_slave_regfile
//  Purpose  : Self-checking bench for apb_slave_regfile; directed scenarios
//             plus random APB traffic compared against a register-map model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regfile;

  localparam int          ADDR_W   = 12;
  localparam int          NUM_REGS = 8;
  localparam logic [31:0] ID_VALUE = 32'hA2B0_0001;

  logic              hclk = 1'b0;
  logic              hreset_n = 1'b0;
  logic              psel = 1'b0;
  logic              penable = 1'b0;
  logic              pwrite = 1'b0;
  logic [ADDR_W-1:0] paddr = '0;
  logic [31:0]       pwdata = '0;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain register map
  logic [31:0] mdl [NUM_REGS];
  logic [3:0]  mdl_wait;

  apb_slave_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE),
    .WAIT_RST (4'd0)
  ) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 hclk = ~hclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'd0;
    mdl_wait = 4'd0;
  endfunction

  function automatic bit mdl_err(input bit wr, input logic [11:0] addr);
    int idx;
    idx = int'(addr) / 4;
    return (addr % 4 != 0) || (idx >= NUM_REGS) || (wr && idx == 0);
  endfunction

  function automatic logic [31:0] mdl_read(input logic [11:0] addr);
    int idx;
    idx = int'(addr) / 4;
    if (idx == 0) return ID_VALUE;
    if (idx == 1) return {28'd0, mdl_wait};
    return mdl[idx];
  endfunction

  // One complete APB transfer; counts the access cycles with pready low.
  task automatic xfer(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic slverr, output int waits);
    @(negedge hclk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    check("setup_rdy", {31'd0, pready}, 32'd0);
    @(negedge hclk);
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 40) begin
      check("wait_rdata", prdata, 32'd0);
      check("wait_err", {31'd0, pslverr}, 32'd0);
      @(negedge hclk);
      // Bus noise during access must be ignored by the completer.
      paddr  = 12'($urandom);
      pwdata = $urandom;
      waits++;
    end
    if (!pready) check("rdy_timeout", {31'd0, pready}, 32'd1);
    rdata  = prdata;
    slverr = pslverr;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          e;
    int          ew;
    e  = mdl_err(1'b1, addr);
    ew = int'(mdl_wait);
    xfer(1'b1, addr, data, rd, se, w);
    check("wr_err", {31'd0, se}, {31'd0, e});
    check("wr_wait", 32'(w), 32'(ew));
    if (!e) begin
      if (addr / 4 == 1) mdl_wait = data[3:0];
      else mdl[addr / 4] = data;
    end
  endtask

  task automatic do_read(input logic [11:0] addr);
    logic [31:0] rd;
    logic        se;
    int          w;
    bit          e;
    int          ew;
    logic [31:0] exp;
    e   = mdl_err(1'b0, addr);
    ew  = int'(mdl_wait);
    exp = e ? 32'd0 : mdl_read(addr);
    xfer(1'b0, addr, 32'd0, rd, se, w);
    check("rd_data", rd, exp);
    check("rd_err", {31'd0, se}, {31'd0, e});
    check("rd_wait", 32'(w), 32'(ew));
  endtask

  task automatic bus_idle();
    @(negedge hclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    mdl_reset();

    // Reset state
    repeat (3) @(negedge hclk);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    hreset_n = 1'b1;
    bus_idle();

    // ID read, zero-wait
    do_read(12'h000);

    // Scratch write/readback
    do_write(12'h008, 32'h1234_5678);
    do_read(12'h008);
    do_read(12'h00C);

    // Wait states
    do_write(12'h004, 32'h0000_0003);
    do_read(12'h008);
    do_read(12'h004);

    // Error responses
    do_write(12'h000, 32'hFFFF_FFFF);
    do_read(12'h000);
    do_read(12'h020);
    do_write(12'h009, 32'hDEAD_BEEF);
    do_read(12'h008);
    do_read(12'h00A);

    // Back-to-back, zero wait
    do_write(12'h004, 32'h0000_0000);
    do_write(12'h00C, 32'hA5A5_A5A5);
    do_read(12'h00C);
    bus_idle();

    // Abort: drop psel two access cycles into a 5-wait write
    do_write(12'h004, 32'h0000_0005);
    @(negedge hclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    penable = 1'b1;
    check("abort_rdy0", {31'd0, pready}, 32'd0);
    @(negedge hclk);
    check("abort_rdy1", {31'd0, pready}, 32'd0);
    @(negedge hclk);
    psel = 1'b0; penable = 1'b0;
    check("abort_rdy2", {31'd0, pready}, 32'd0);
    @(negedge hclk);
    check("abort_idle", {31'd0, pready}, 32'd0);
    do_read(12'h010);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 47));
      if ($urandom_range(0, 1) == 1) do_write(a, $urandom);
      else do_read(a);
      if ($urandom_range(0, 3) == 0) bus_idle();
    end

    // Reset pulse in the middle of a stalled transfer
    do_write(12'h004, 32'h0000_0006);
    do_write(12'h008, 32'h5555_AAAA);
    @(negedge hclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h008;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1;
    check("midrst_pready", {31'd0, pready}, 32'd0);
    check("midrst_prdata", prdata, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    mdl_reset();
    @(negedge hclk);
    hreset_n = 1'b1;
    do_read(12'h004);
    do_read(12'h008);
    bus_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
